uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_if.sv | 24 ++
 rtl/uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-queue side of the UART transmitter: write strobe and word in, serial line and FIFO status out.
// Writes are never stalled; a write into a full queue is dropped and reported on txdOverflow.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          txdStart;
    logic [DATA_BITS-1:0]          data;
    logic                          txd;
    logic                          txdBusy;
    logic                          txdFull;
    logic                          txdOverflow;
    logic [$clog2(FIFO_DEPTH):0]   fifoCount;

    modport master (
        output txdStart, data,
        input  txd, txdBusy, txdFull, txdOverflow, fifoCount
    );

    modport slave (
        input  txdStart, data,
        output txd, txdBusy, txdFull, txdOverflow, fifoCount
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO and fractional baud generator; start bit reaches the pin one cycle after the pop.
// No stall on the write side: writes into a full FIFO are dropped and flagged with a one-cycle txdOverflow pulse.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wrVld,
    input  logic [WIDTH-1:0]           wrDat,
    input  logic                       rdRdy,
    output logic                       rdVld,
    output logic [WIDTH-1:0]           rdDat,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             wrEn;
    logic             rdEn;

    assign full  = (count == CW'(DEPTH));
    assign rdVld = (count != '0);
    assign rdDat = mem[rdPtr];
    // Fullness is judged on the current count, so a same-cycle pop never frees room for a write.
    assign wrEn  = wrVld && !full;
    assign rdEn  = rdRdy && rdVld;

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= wrDat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (rdEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({wrEn, rdEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 9600,
    parameter int ACC_WIDTH  = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_fifo_if.slave    bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [63:0] INC_CALC =
        ((64'(BAUD) << (ACC_WIDTH - 4)) + (64'(CLK_FREQ) >> 5)) / (64'(CLK_FREQ) >> 4);
    localparam logic [ACC_WIDTH-1:0] INC = INC_CALC[ACC_WIDTH-1:0];
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [2:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;
    logic                 tick;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] head;
    logic                 parBit;
    logic                 headPar;
    logic [3:0]           bitCnt;
    logic                 stopCnt;
    logic                 lastStop;
    logic                 txdReg;
    logic                 overflowReg;
    logic                 fifoVld;
    logic                 fifoFull;
    logic                 pop;
    logic [CW-1:0]        count;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) txFifo (
        .clk   (clk),
        .reset (reset),
        .wrVld (bus.txdStart),
        .wrDat (bus.data),
        .rdRdy (pop),
        .rdVld (fifoVld),
        .rdDat (head),
        .full  (fifoFull),
        .count (count)
    );

    // Carry out of the phase accumulator marks the end of each bit period.
    assign sum      = {1'b0, acc} + {1'b0, INC};
    assign tick     = sum[ACC_WIDTH] && (state != IDLE);
    assign lastStop = (stopCnt == LAST_STOP);
    assign headPar  = (PARITY == 1) ? ~(^head) : ^head;
    assign pop      = fifoVld && ((state == IDLE) || (state == STOP && tick && lastStop));

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
        end else if (state == IDLE) begin
            acc <= '0;
        end else begin
            acc <= sum[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            txdReg   <= 1'b1;
            shiftReg <= '0;
            parBit   <= 1'b0;
            bitCnt   <= '0;
            stopCnt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txdReg <= 1'b1;
                    if (fifoVld) begin
                        shiftReg <= head;
                        parBit   <= headPar;
                        state    <= START;
                        txdReg   <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state    <= DATA;
                        txdReg   <= shiftReg[0];
                        shiftReg <= shiftReg >> 1;
                        bitCnt   <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bitCnt == LAST_BIT) begin
                            stopCnt <= 1'b0;
                            if (PARITY != 0) begin
                                state  <= PAR;
                                txdReg <= parBit;
                            end else begin
                                state  <= STOP;
                                txdReg <= 1'b1;
                            end
                        end else begin
                            txdReg   <= shiftReg[0];
                            shiftReg <= shiftReg >> 1;
                            bitCnt   <= bitCnt + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (tick) begin
                        state   <= STOP;
                        txdReg  <= 1'b1;
                        stopCnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (!lastStop) begin
                            stopCnt <= stopCnt + 1'b1;
                        end else if (fifoVld) begin
                            // Chain straight into the next start bit so queued frames leave back-to-back.
                            shiftReg <= head;
                            parBit   <= headPar;
                            state    <= START;
                            txdReg   <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            txdReg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    txdReg <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflowReg <= 1'b0;
        end else begin
            overflowReg <= bus.txdStart && fifoFull;
        end
    end

    assign bus.txd         = txdReg;
    assign bus.txdBusy     = fifoVld || (state != IDLE);
    assign bus.txdFull     = fifoFull;
    assign bus.txdOverflow = overflowReg;
    assign bus.fifoCount   = count;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 153600 Hz / 9600 baud gives 16-cycle bits across several frame formats.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   sel = 0;
    logic selTxd;
    logic selBusy;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) b8n1 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) b8e1 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) b8o1 ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(16)) b7o2 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  b4   ();

    uart_tx_fifo #(.CLK_FREQ(153600), .BAUD(9600), .ACC_WIDTH(16), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
        u8n1 (.clk(clk), .reset(reset), .bus(b8n1));
    uart_tx_fifo #(.CLK_FREQ(153600), .BAUD(9600), .ACC_WIDTH(16), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
        u8e1 (.clk(clk), .reset(reset), .bus(b8e1));
    uart_tx_fifo #(.CLK_FREQ(153600), .BAUD(9600), .ACC_WIDTH(16), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16))
        u8o1 (.clk(clk), .reset(reset), .bus(b8o1));
    uart_tx_fifo #(.CLK_FREQ(153600), .BAUD(9600), .ACC_WIDTH(16), .DATA_BITS(7),
                   .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16))
        u7o2 (.clk(clk), .reset(reset), .bus(b7o2));
    uart_tx_fifo #(.CLK_FREQ(153600), .BAUD(9600), .ACC_WIDTH(16), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u4 (.clk(clk), .reset(reset), .bus(b4));

    always_comb begin
        selTxd  = 1'b1;
        selBusy = 1'b0;
        case (sel)
            0: begin selTxd = b8n1.txd; selBusy = b8n1.txdBusy; end
            1: begin selTxd = b8e1.txd; selBusy = b8e1.txdBusy; end
            2: begin selTxd = b8o1.txd; selBusy = b8o1.txdBusy; end
            3: begin selTxd = b7o2.txd; selBusy = b7o2.txdBusy; end
            4: begin selTxd = b4.txd;   selBusy = b4.txdBusy;   end
            default: begin selTxd = 1'b1; selBusy = 1'b0; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 'skip' cycles into bit 0; checks first and last cycle of every bit period.
    task automatic checkFrame(input string tag, input logic [15:0] frame, input int nbits, input int skip);
        int off;
        off = skip;
        for (int k = 0; k < nbits; k++) begin
            check({tag, " bit head"}, 32'(selTxd), 32'(frame[k]));
            repeat (15 - off) step();
            check({tag, " bit tail"}, 32'(selTxd), 32'(frame[k]));
            if (k == nbits - 1) begin
                check({tag, " busy in frame"}, 32'(selBusy), 32'd1);
            end
            step();
            off = 0;
        end
    endtask

    initial begin
        logic [7:0]  bytes [5];
        logic [15:0] f;
        bytes[0] = 8'hA1; bytes[1] = 8'hA2; bytes[2] = 8'hA3; bytes[3] = 8'hA4; bytes[4] = 8'hA5;
        b8n1.txdStart = 1'b0; b8n1.data = '0;
        b8e1.txdStart = 1'b0; b8e1.data = '0;
        b8o1.txdStart = 1'b0; b8o1.data = '0;
        b7o2.txdStart = 1'b0; b7o2.data = '0;
        b4.txdStart   = 1'b0; b4.data   = '0;

        repeat (3) step();
        check("rst txd",      32'(b8n1.txd),         32'd1);
        check("rst count",    32'(b8n1.fifoCount),   32'd0);
        check("rst busy",     32'(b8n1.txdBusy),     32'd0);
        check("rst full",     32'(b8n1.txdFull),     32'd0);
        check("rst overflow", 32'(b8n1.txdOverflow), 32'd0);
        check("rst txd d4",   32'(b4.txd),           32'd1);
        reset = 1'b1;
        repeat (2) step();

        // 8N1, 0x55
        sel = 0;
        b8n1.txdStart = 1'b1; b8n1.data = 8'h55;
        step();
        b8n1.txdStart = 1'b0;
        check("8n1 count after W", 32'(b8n1.fifoCount), 32'd1);
        check("8n1 txd idle at W", 32'(b8n1.txd),       32'd1);
        check("8n1 busy at W",     32'(b8n1.txdBusy),   32'd1);
        step();
        check("8n1 count after pop", 32'(b8n1.fifoCount), 32'd0);
        checkFrame("8n1", 16'h02AA, 10, 0);
        check("8n1 busy end", 32'(b8n1.txdBusy), 32'd0);
        check("8n1 txd end",  32'(b8n1.txd),     32'd1);

        // 8E1, 0x07: parity 1
        sel = 1;
        b8e1.txdStart = 1'b1; b8e1.data = 8'h07;
        step();
        b8e1.txdStart = 1'b0;
        step();
        checkFrame("8e1", 16'h060E, 11, 0);
        check("8e1 busy end", 32'(b8e1.txdBusy), 32'd0);

        // 8O1, 0x07: parity 0
        sel = 2;
        b8o1.txdStart = 1'b1; b8o1.data = 8'h07;
        step();
        b8o1.txdStart = 1'b0;
        step();
        checkFrame("8o1", 16'h040E, 11, 0);
        check("8o1 busy end", 32'(b8o1.txdBusy), 32'd0);

        // 7O2, 0x00: parity 1, two stop bits
        sel = 3;
        b7o2.txdStart = 1'b1; b7o2.data = 7'h00;
        step();
        b7o2.txdStart = 1'b0;
        step();
        checkFrame("7o2", 16'h0700, 11, 0);
        check("7o2 busy end", 32'(b7o2.txdBusy), 32'd0);

        // Depth-4 burst: A1 popped at W2, A2..A5 fill the FIFO, sixth write dropped
        sel = 4;
        b4.txdStart = 1'b1; b4.data = 8'hA1;
        step();
        check("d4 count W1", 32'(b4.fifoCount), 32'd1);
        b4.data = 8'hA2;
        step();
        check("d4 count W2", 32'(b4.fifoCount), 32'd1);
        check("d4 start W2", 32'(b4.txd),       32'd0);
        b4.data = 8'hA3;
        step();
        check("d4 count W3", 32'(b4.fifoCount), 32'd2);
        b4.data = 8'hA4;
        step();
        check("d4 count W4", 32'(b4.fifoCount), 32'd3);
        check("d4 full W4",  32'(b4.txdFull),   32'd0);
        b4.data = 8'hA5;
        step();
        check("d4 count W5", 32'(b4.fifoCount), 32'd4);
        check("d4 full W5",  32'(b4.txdFull),   32'd1);
        check("d4 ovf W5",   32'(b4.txdOverflow), 32'd0);
        b4.data = 8'hA6;
        step();
        b4.txdStart = 1'b0;
        check("d4 ovf W6",   32'(b4.txdOverflow), 32'd1);
        check("d4 count W6", 32'(b4.fifoCount),   32'd4);
        step();
        check("d4 ovf W7",   32'(b4.txdOverflow), 32'd0);
        for (int i = 0; i < 5; i++) begin
            f = 16'h0200 | (16'(bytes[i]) << 1);
            checkFrame("d4 frame", f, 10, (i == 0) ? 5 : 0);
        end
        check("d4 busy end",  32'(b4.txdBusy),   32'd0);
        check("d4 count end", 32'(b4.fifoCount), 32'd0);
        check("d4 txd end",   32'(b4.txd),       32'd1);

        // Reset during data bit 3 of a three-byte burst
        sel = 0;
        b8n1.txdStart = 1'b1; b8n1.data = 8'h11;
        step();
        b8n1.data = 8'h22;
        step();
        b8n1.data = 8'h33;
        step();
        b8n1.txdStart = 1'b0;
        check("mid count W3", 32'(b8n1.fifoCount), 32'd2);
        repeat (71) step();
        check("mid data bit3", 32'(b8n1.txd),       32'd0);
        check("mid busy",      32'(b8n1.txdBusy),   32'd1);
        reset = 1'b0;
        step();
        check("mid rst txd",   32'(b8n1.txd),       32'd1);
        check("mid rst count", 32'(b8n1.fifoCount), 32'd0);
        check("mid rst busy",  32'(b8n1.txdBusy),   32'd0);
        reset = 1'b1;
        repeat (20) step();
        check("post rst idle txd",  32'(b8n1.txd),     32'd1);
        check("post rst idle busy", 32'(b8n1.txdBusy), 32'd0);
        b8n1.txdStart = 1'b1; b8n1.data = 8'h55;
        step();
        b8n1.txdStart = 1'b0;
        step();
        checkFrame("post rst", 16'h02AA, 10, 0);
        check("post rst busy end", 32'(b8n1.txdBusy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
